// File: rtl/fifo_512_60bit_ctrl_pkg.sv
// Shared definitions for the 512x60 FIFO controller: FSM encoding, depth and
// the almost-full threshold helper.
package fifo_512_60bit_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } ctrl_state_e;

  localparam int FIFO_AW    = 9;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  function automatic int af_threshold(input int aw, input int margin);
    return (1 << aw) - margin;
  endfunction

endpackage

// File: rtl/fifo_512_60bit_ctrl_arb.sv
// Round-robin push arbiter: the search starts one past the last winner and
// returns a one-hot grant plus the encoded winner index.
module fifo_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
  input  logic                    en_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] gnt_idx_o,
  output logic                    gnt_any_o
);

  localparam int IW = $clog2(NREQ);

  int            pos;
  logic [IW-1:0] pos_idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos     = (int'(rr_ptr_i) + k) % NREQ;
      pos_idx = IW'(pos);
      if (en_i && !gnt_any_o && req_i[pos_idx]) begin
        gnt_o[pos_idx] = 1'b1;
        gnt_idx_o      = pos_idx;
        gnt_any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_512_60bit_ctrl.sv
// Shares one 512x60 FIFO between NREQ producers and one consumer; tracks a
// shadow level and runs drain/clear flushes. FIFO_CTRL_STATS_EN adds counters.
//
// state    | meaning
// ST_RUN   | normal push/pop traffic
// ST_DRAIN | pushes blocked, pops continue until the FIFO has fully delivered
// ST_CLEAR | one-cycle FIFO clear, level forced to zero
module fifo_512_60bit_ctrl
  import fifo_512_60bit_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 60,
  parameter int AW        = FIFO_AW,
  parameter int AF_MARGIN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               almost_full,
  output logic [AW:0]        level,
  input  logic               pop_req,
  output logic               pop_valid,
  output logic [DW-1:0]      pop_data,
  input  logic               drain_req,
  output logic               drain_done,
  output logic               busy,
  output logic [DW-1:0]      fifo_din,
  output logic               fifo_we,
  output logic               fifo_re,
  output logic               fifo_clr,
  input  logic [DW-1:0]      fifo_dout,
  input  logic               fifo_full,
  input  logic               fifo_empty
`ifdef FIFO_CTRL_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int          IW      = $clog2(NREQ);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF_TH   = (AW+1)'(af_threshold(AW, AF_MARGIN));

  ctrl_state_e   state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] win_idx;
  logic          win_any;
  logic          push_ok;
  logic [AW:0]   level_q, level_d;
  logic          pop_valid_q, drain_done_q, almost_full_q;

  // drain_req blocks the arbiter in the same cycle it is seen in RUN
  assign push_ok = (state_q == ST_RUN) && !fifo_full && !drain_req;

  fifo_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i     (req),
    .rr_ptr_i  (rr_ptr_q),
    .en_i      (push_ok),
    .gnt_o     (gnt),
    .gnt_idx_o (win_idx),
    .gnt_any_o (win_any)
  );

  assign fifo_we  = win_any;
  assign fifo_din = req_data[int'(win_idx)*DW +: DW];
  assign fifo_re  = pop_req && !fifo_empty && (state_q != ST_CLEAR);
  assign fifo_clr = !rst || (state_q == ST_CLEAR);

  assign busy        = (state_q != ST_RUN);
  assign level       = level_q;
  assign almost_full = almost_full_q;
  assign pop_valid   = pop_valid_q;
  assign pop_data    = fifo_dout;
  assign drain_done  = drain_done_q;

  always_comb begin
    level_d = level_q;
    if (state_q == ST_CLEAR)       level_d = '0;
    else if (fifo_we && !fifo_re)  level_d = level_q + 1'b1;
    else if (!fifo_we && fifo_re)  level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      rr_ptr_q      <= '0;
      level_q       <= '0;
      pop_valid_q   <= 1'b0;
      drain_done_q  <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= level_d;
      almost_full_q <= (level_d >= AF_TH);
      pop_valid_q   <= fifo_re;
      drain_done_q  <= (state_q == ST_CLEAR);
      if (win_any) rr_ptr_q <= win_idx;
      case (state_q)
        ST_RUN:   if (drain_req) state_q <= ST_DRAIN;
        // wait for the registered read of the last word to reach the consumer
        ST_DRAIN: if (fifo_empty && !pop_valid_q) state_q <= ST_CLEAR;
        ST_CLEAR: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

`ifdef FIFO_CTRL_STATS_EN
  logic [NREQ*16-1:0] grant_cnt_q;
  logic [15:0]        stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst || state_q == ST_CLEAR) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
      end
      if (|req && !push_ok) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_we && !fifo_re && level_q == DEPTH_L));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_re && !fifo_we && level_q == '0));

endmodule

// File: tb/tb_fifo_512_60bit_ctrl.sv
// Self-checking bench for fifo_512_60bit_ctrl with a behavioural 512x60 FIFO
// and a queue-based reference model compared every cycle.
module tb_fifo_512_60bit_ctrl;

  localparam int NREQ  = 4;
  localparam int DW    = 60;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int AFM   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic               pop_req = 1'b0;
  logic               drain_req = 1'b0;
  logic [NREQ-1:0]    gnt;
  logic               almost_full, pop_valid, drain_done, busy;
  logic [AW:0]        level;
  logic [DW-1:0]      pop_data, fifo_din, fifo_dout;
  logic               fifo_we, fifo_re, fifo_clr, fifo_full, fifo_empty;
`ifdef FIFO_CTRL_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [15:0]        stall_cnt;
`endif

  fifo_512_60bit_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .almost_full(almost_full), .level(level), .pop_req(pop_req),
    .pop_valid(pop_valid), .pop_data(pop_data), .drain_req(drain_req),
    .drain_done(drain_done), .busy(busy), .fifo_din(fifo_din),
    .fifo_we(fifo_we), .fifo_re(fifo_re), .fifo_clr(fifo_clr),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef FIFO_CTRL_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural 512x60 FIFO: registered read, clear has priority, rst = ~rst
  logic [DW-1:0] fmem [DEPTH];
  logic [AW-1:0] fwp = '0, frp = '0;
  int            fcnt = 0;
  logic          fifo_rst;
  assign fifo_rst   = ~rst;
  assign fifo_full  = (fcnt == DEPTH);
  assign fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (fifo_rst || fifo_clr) begin
      fwp  <= '0;
      frp  <= '0;
      fcnt <= 0;
    end else begin
      if (fifo_we && !fifo_full) begin
        fmem[fwp] <= fifo_din;
        fwp       <= fwp + 1'b1;
      end
      if (fifo_re && !fifo_empty) begin
        fifo_dout <= fmem[frp];
        frp       <= frp + 1'b1;
      end
      fcnt <= fcnt + ((fifo_we && !fifo_full) ? 1 : 0) - ((fifo_re && !fifo_empty) ? 1 : 0);
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue holds the words the FIFO should contain
  logic [DW-1:0]   mq[$];
  int              m_ptr = 0;
  int              m_phase = 0;
  bit              m_pv = 0, m_done = 0;
  logic [DW-1:0]   m_pdata = '0;
  bit              chk_en = 0;
  int              e_win, idx;
  bit              e_full, e_empty, e_ok, e_re, pv_old;
  logic [NREQ-1:0] e_gnt;

  always @(negedge clk) begin
    if (chk_en) begin
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      e_ok    = (m_phase == 0) && !e_full && !drain_req;
      e_win   = -1;
      if (e_ok) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (e_win < 0 && req[idx]) e_win = idx;
        end
      end
      e_gnt = '0;
      if (e_win >= 0) e_gnt[e_win] = 1'b1;
      e_re = pop_req && !e_empty && (m_phase != 2);

      check("gnt", gnt, e_gnt);
      check("fifo_we", fifo_we, e_win >= 0);
      if (e_win >= 0) check("fifo_din", fifo_din, req_data[e_win*DW +: DW]);
      check("fifo_re", fifo_re, e_re);
      check("fifo_clr", fifo_clr, !rst || m_phase == 2);
      check("busy", busy, m_phase != 0);
      check("level", level, mq.size());
      check("almost_full", almost_full, mq.size() >= DEPTH - AFM);
      check("pop_valid", pop_valid, m_pv);
      if (m_pv) check("pop_data", pop_data, m_pdata);
      check("drain_done", drain_done, m_done);

      pv_old = m_pv;
      if (!rst) begin
        mq.delete();
        m_ptr = 0; m_phase = 0; m_pv = 0; m_done = 0;
      end else begin
        m_done = (m_phase == 2);
        m_pv   = e_re;
        if (e_re) m_pdata = mq.pop_front();
        if (e_win >= 0) begin
          mq.push_back(req_data[e_win*DW +: DW]);
          m_ptr = e_win;
        end
        case (m_phase)
          0: if (drain_req) m_phase = 1;
          1: if (e_empty && !pv_old) m_phase = 2;
          default: begin m_phase = 0; mq.delete(); end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'(64'h0111_1111_1111_1111 * (i + 1));
  endfunction

  int exp_order [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int nv, gi, pushes, af_lvl, gbad, nvalid, nclr, nd;
  bit got_full, done_seen, prev_clr, saw_busy;

  initial begin
    rst = 1'b0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_level", level, 0);
    check("rst_af", almost_full, 0);
    check("rst_busy", busy, 0);
    check("rst_pop_valid", pop_valid, 0);
    tick();

    // Fairness: all four requesters, eight grants
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word_of(i);
    req = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      gi = -1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
      check("fair_order", gi, exp_order[c]);
      tick();
    end
    req = '0;
    @(negedge clk);
    check("fair_level", level, 8);
    tick();
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      pop_req = (c < 8);
      @(negedge clk);
      if (pop_valid) begin
        if (nv < 8) check("fair_data", pop_data, word_of(exp_order[nv]));
        nv++;
      end
      tick();
    end
    check("fair_nvalid", nv, 8);

    // Fill from empty with requester 0
    pushes = 0; af_lvl = -1; got_full = 0;
    req = 4'b0001;
    for (int c = 0; c < 600 && !got_full; c++) begin
      req_data[0 +: DW] = DW'(64'hC00_0000_0000_0000 + 64'(pushes));
      @(negedge clk);
      if (almost_full && af_lvl < 0) af_lvl = int'(level);
      if (fifo_full) begin
        got_full = 1;
        check("full_no_gnt", gnt, 0);
      end else if (gnt[0]) pushes++;
      tick();
    end
    req = '0;
    check("fill_got_full", got_full, 1);
    check("fill_pushes", pushes, 512);
    check("fill_af_level", af_lvl, 504);
    @(negedge clk);
    check("fill_level", level, 512);
    tick();

    // Concurrent push/pop at 511
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    @(negedge clk);
    check("l511_level", level, 511);
    tick();
    req = 4'b0001; pop_req = 1'b1;
    tick();
    req = '0; pop_req = 1'b0;
    @(negedge clk);
    check("pp_level", level, 511);
    check("pp_full", fifo_full, 0);
    tick();
    req = 4'b0001;
    tick();
    req = '0;
    @(negedge clk);
    check("top_level", level, 512);
    check("top_full", fifo_full, 1);
    tick();

    // Empty it out
    pop_req = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (level == 0) break;
      tick();
    end
    tick();
    pop_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("emptied_level", level, 0);
    tick();

    // Pop latency with a single word
    req_data[2*DW +: DW] = 60'h0AB_CDEF_0123_4567;
    req = 4'b0100;
    tick();
    req = '0;
    pop_req = 1'b1;
    @(negedge clk);
    check("lat_re", fifo_re, 1);
    tick();
    pop_req = 1'b0;
    @(negedge clk);
    check("lat_valid", pop_valid, 1);
    check("lat_data", pop_data, 60'h0AB_CDEF_0123_4567);
    tick();
    @(negedge clk);
    check("lat_valid_off", pop_valid, 0);
    pop_req = 1'b0;
    tick();
    pop_req = 1'b1;
    @(negedge clk);
    check("empty_no_re", fifo_re, 0);
    tick();
    pop_req = 1'b0;
    @(negedge clk);
    check("empty_no_valid", pop_valid, 0);
    tick();

    // Drain from level 5
    req = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      req_data[1*DW +: DW] = DW'(64'h500 + 64'(c));
      tick();
    end
    req = '0;
    @(negedge clk);
    check("drain_start_level", level, 5);
    tick();
    req = 4'hF; drain_req = 1'b1; pop_req = 1'b1;
    gbad = 0; nvalid = 0; nclr = 0; done_seen = 0; prev_clr = 0; saw_busy = 0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      if (gnt != '0) gbad++;
      if (drain_done) begin
        done_seen = 1;
        check("drain_clr_before_done", prev_clr, 1);
        check("drain_done_busy", busy, 0);
        check("drain_done_level", level, 0);
      end else begin
        if (pop_valid) nvalid++;
        if (fifo_clr) nclr++;
        prev_clr = fifo_clr;
        if (busy) saw_busy = 1;
      end
      tick();
      if (saw_busy) begin req = '0; drain_req = 1'b0; end
    end
    pop_req = 1'b0;
    req = '0; drain_req = 1'b0;
    check("drain_seen", done_seen, 1);
    check("drain_no_gnt", gbad, 0);
    check("drain_valids", nvalid, 5);
    check("drain_clr_cycles", nclr, 1);
    tick();

    // Reset in the middle of a drain at level 3
    req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      req_data[3*DW +: DW] = DW'(64'h300 + 64'(c));
      tick();
    end
    req = '0;
    @(negedge clk);
    check("rmd_level", level, 3);
    tick();
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    @(negedge clk);
    check("rmd_busy", busy, 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rmd_clr", fifo_clr, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rmd_busy_after", busy, 0);
    check("rmd_level_after", level, 0);
    check("rmd_empty", fifo_empty, 1);
    nd = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      if (drain_done) nd++;
    end
    check("rmd_no_done", nd, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t, expected end before 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
